dc_node_monitor: RTL and testbench

- Digital measurement stage downstream of the DC source / series-element / load test circuit.
- Consumes a stream of converted samples of the load-node voltage (node "out") and waits until that node has settled.
- Averages a fixed window of settled samples and reports the mean and a settled/timeout flag through a valid/ready result port.
- Feeds the bench checker that compares the measured DC operating point against the expected value.

---
 rtl/dc_node_monitor.sv | 151 +++++++++++++++
 tb/tb_dc_node_monitor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dc_node_monitor.sv
// DC node monitor: waits for the sampled load-node voltage to settle, then averages a window.
// Optional macro DC_NODE_MONITOR_MINMAX_EN adds window min/max result outputs.
module dc_node_monitor #(
    parameter int unsigned DW          = 12,
    parameter int unsigned WIN_LOG2    = 4,
    parameter int unsigned TOL         = 4,
    parameter int unsigned SETTLE_CNT  = 8,
    parameter int unsigned MAX_SAMPLES = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_mean,
    output logic          m_settled,
`ifdef DC_NODE_MONITOR_MINMAX_EN
    output logic [DW-1:0] m_min,
    output logic [DW-1:0] m_max,
`endif
    output logic          busy
);
    localparam int unsigned   AW           = DW + WIN_LOG2;
    localparam logic [DW-1:0] TolCode      = DW'(TOL);
    localparam logic [7:0]    SettleTarget = 8'(SETTLE_CNT);
    localparam logic [15:0]   MaxTarget    = 16'(MAX_SAMPLES);

    typedef enum logic [1:0] {StIdle, StSettle, StAccum, StDone} state_e;

    state_e              state_q;
    logic [7:0]          stable_cnt_q, stable_cnt_d;
    logic [15:0]         sample_cnt_q, sample_cnt_d;
    logic [WIN_LOG2-1:0] win_cnt_q;
    logic [DW-1:0]       prev_q, delta;
    logic                have_prev_q;
    logic [AW-1:0]       acc_q, acc_sum;
    logic                accept, result_accept, win_last;
`ifdef DC_NODE_MONITOR_MINMAX_EN
    logic [DW-1:0]       min_q, max_q, win_min, win_max;
`endif

    assign s_ready       = (state_q == StSettle) || (state_q == StAccum);
    assign m_valid       = (state_q == StDone);
    assign busy          = (state_q != StIdle);
    assign accept        = s_valid & s_ready;
    assign result_accept = m_valid & m_ready;
    assign win_last      = &win_cnt_q;

    always_comb begin
        delta = (s_data >= prev_q) ? (s_data - prev_q) : (prev_q - s_data);
        // The first sample after start has no predecessor and never counts as stable.
        if (!have_prev_q) begin
            stable_cnt_d = '0;
        end else if (delta <= TolCode) begin
            stable_cnt_d = stable_cnt_q + 8'd1;
        end else begin
            stable_cnt_d = '0;
        end
        sample_cnt_d = sample_cnt_q + 16'd1;
        acc_sum      = acc_q + AW'(s_data);
`ifdef DC_NODE_MONITOR_MINMAX_EN
        win_min = (win_cnt_q == '0 || s_data < min_q) ? s_data : min_q;
        win_max = (win_cnt_q == '0 || s_data > max_q) ? s_data : max_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            stable_cnt_q <= '0;
            sample_cnt_q <= '0;
            win_cnt_q    <= '0;
            prev_q       <= '0;
            have_prev_q  <= 1'b0;
            acc_q        <= '0;
            m_mean       <= '0;
            m_settled    <= 1'b0;
`ifdef DC_NODE_MONITOR_MINMAX_EN
            min_q        <= '0;
            max_q        <= '0;
            m_min        <= '0;
            m_max        <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        stable_cnt_q <= '0;
                        sample_cnt_q <= '0;
                        win_cnt_q    <= '0;
                        prev_q       <= '0;
                        have_prev_q  <= 1'b0;
                        acc_q        <= '0;
                        state_q      <= StSettle;
                    end
                end
                StSettle: begin
                    if (accept) begin
                        sample_cnt_q <= sample_cnt_d;
                        prev_q       <= s_data;
                        have_prev_q  <= 1'b1;
                        stable_cnt_q <= stable_cnt_d;
                        // Settling wins over timeout on the same sample.
                        if (stable_cnt_d == SettleTarget) begin
                            acc_q     <= '0;
                            win_cnt_q <= '0;
                            state_q   <= StAccum;
                        end else if (sample_cnt_d == MaxTarget) begin
                            m_mean    <= s_data;
                            m_settled <= 1'b0;
`ifdef DC_NODE_MONITOR_MINMAX_EN
                            m_min     <= s_data;
                            m_max     <= s_data;
`endif
                            state_q   <= StDone;
                        end
                    end
                end
                StAccum: begin
                    if (accept) begin
                        acc_q     <= acc_sum;
                        win_cnt_q <= win_cnt_q + WIN_LOG2'(1);
`ifdef DC_NODE_MONITOR_MINMAX_EN
                        min_q     <= win_min;
                        max_q     <= win_max;
`endif
                        if (win_last) begin
                            m_mean    <= DW'(acc_sum >> WIN_LOG2);
                            m_settled <= 1'b1;
`ifdef DC_NODE_MONITOR_MINMAX_EN
                            m_min     <= win_min;
                            m_max     <= win_max;
`endif
                            state_q   <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (result_accept) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dc_node_monitor.sv
// Randomized bench for dc_node_monitor against a queue-based reference model.
module tb_dc_node_monitor;
    localparam int DW          = 12;
    localparam int WIN_LOG2    = 4;
    localparam int TOL         = 4;
    localparam int SETTLE_CNT  = 8;
    localparam int MAX_SAMPLES = 1024;
    localparam int WIN         = 1 << WIN_LOG2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_mean;
    logic          m_settled;
    logic          busy;
`ifdef DC_NODE_MONITOR_MINMAX_EN
    logic [DW-1:0] m_min, m_max;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dc_node_monitor #(
        .DW(DW), .WIN_LOG2(WIN_LOG2), .TOL(TOL), .SETTLE_CNT(SETTLE_CNT),
        .MAX_SAMPLES(MAX_SAMPLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_mean(m_mean),
        .m_settled(m_settled),
`ifdef DC_NODE_MONITOR_MINMAX_EN
        .m_min(m_min), .m_max(m_max),
`endif
        .busy(busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: walk the accepted samples using the measurement rules directly.
    function automatic void model(input int q[$], output int n, output int mean,
                                  output int settled, output int mn, output int mx);
        int stable = 0;
        int s_idx = -1;
        int sum = 0;
        n = -1; mean = 0; settled = 0; mn = 0; mx = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (i > 0) begin
                int d = q[i] - q[i-1];
                if (d < 0) d = -d;
                stable = (d <= TOL) ? stable + 1 : 0;
            end
            if (stable == SETTLE_CNT) begin
                s_idx = i;
                break;
            end
            if (i + 1 == MAX_SAMPLES) begin
                n = i + 1; mean = q[i]; mn = q[i]; mx = q[i];
                return;
            end
        end
        if (s_idx < 0) return;
        n = s_idx + 1 + WIN;
        settled = 1;
        mn = 1 << DW; mx = -1;
        for (int i = s_idx + 1; i < n && i < q.size(); i++) begin
            sum += q[i];
            if (q[i] < mn) mn = q[i];
            if (q[i] > mx) mx = q[i];
        end
        mean = sum / WIN;
    endfunction

    function automatic logic [DW-1:0] gen(input int mode, input int idx);
        case (mode)
            0: return 12'd2048;
            1: case (idx)
                   0: return 12'd0;
                   1: return 12'd1000;
                   2: return 12'd1600;
                   3: return 12'd1900;
                   4: return 12'd2000;
                   5: return 12'd2040;
                   default: return 12'd2048;
               endcase
            2: return (idx % 2 == 0) ? 12'd1000 : 12'd1010;
            3: return (idx == 24) ? 12'd115 : 12'd100;
            default: return 12'(2000 + $urandom_range(0, 5));
        endcase
    endfunction

    // One measurement; stop_after>0 abandons it after that many accepted samples.
    task automatic run(input int mode, input int gap, input int hold, input int stop_after);
        int q[$];
        int idx = 0;
        bit done = 0;
        int n, mean, settled, mn, mx;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_ready", {31'd0, s_ready}, 1);
        check_eq("start_busy", {31'd0, busy}, 1);
        for (int c = 0; c < 3000 && !done; c++) begin
            if (m_valid) begin
                done = 1;
            end else if (stop_after > 0 && idx == stop_after) begin
                break;
            end else begin
                s_valid = (gap == 0) ? 1'b1 : ($urandom_range(0, 99) >= gap);
                s_data  = gen(mode, idx);
                start   = (c % 7 == 3);
                if (s_valid && s_ready) begin
                    q.push_back(int'(s_data));
                    idx++;
                end
                @(negedge clk);
            end
        end
        s_valid = 1'b0;
        start   = 1'b0;
        if (stop_after > 0) return;
        if (!done) begin
            check_eq("result_timeout", 0, 1);
            return;
        end
        model(q, n, mean, settled, mn, mx);
        check_eq("sample_count", q.size(), n);
        check_eq("mean", {20'd0, m_mean}, mean);
        check_eq("settled", {31'd0, m_settled}, settled);
`ifdef DC_NODE_MONITOR_MINMAX_EN
        check_eq("min", {20'd0, m_min}, mn);
        check_eq("max", {20'd0, m_max}, mx);
`endif
        for (int h = 0; h < hold; h++) begin
            m_ready = 1'b0;
            start   = (h % 3 == 1);
            @(negedge clk);
            check_eq("hold", {19'd0, m_valid, m_mean}, {19'd0, 1'b1, 12'(mean)});
        end
        start   = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check_eq("after_accept", {29'd0, m_valid, busy, s_ready}, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_outputs", {28'd0, s_ready, m_valid, m_settled, busy}, 0);
        check_eq("rst_mean", {20'd0, m_mean}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_ready", {31'd0, s_ready}, 0);

        run(0, 0, 0, 0);   // constant node
        run(0, 0, 0, 15);  // abandon mid-window
        rst_n = 1'b0;
        #1;
        check_eq("midrst_outputs", {28'd0, s_ready, m_valid, m_settled, busy}, 0);
        check_eq("midrst_mean", {20'd0, m_mean}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 0, 0, 0);
        run(1, 0, 0, 0);   // RC approach
        run(2, 0, 0, 0);   // never settles
        run(3, 0, 2, 0);   // truncating mean
        run(3, 30, 5, 0);
        for (int k = 0; k < 6; k++) run(4, 40, 20, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
